// File: rtl/al_ram_init_sequencer.sv
// Initialisation / partition re-enable sweeper for the active-list next-PC RAM.
// Owns the RAM write port while sweeping, otherwise passes producer writes through.
module al_ram_init_sequencer #(
    parameter int                 DEPTH     = 16,
    parameter int                 INDEX     = 4,
    parameter int                 WIDTH     = 8,
    parameter int                 NUM_PARTS = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PARTS-1:0] partitionActive_i,
    input  logic                 reconfig_i,
    input  logic                 wrEn_i,
    input  logic [INDEX-1:0]     wrAddr_i,
    input  logic [WIDTH-1:0]     wrData_i,
    output logic                 wrStall_o,
    output logic                 ramWe_o,
    output logic [INDEX-1:0]     ramAddr_o,
    output logic [WIDTH-1:0]     ramData_o,
    output logic                 ready_o,
    output logic                 initDone_o,
    output logic                 illegalWr_o,
    output logic [NUM_PARTS-1:0] activeMask_o
);

    localparam int PART_SIZE = DEPTH / NUM_PARTS;
    localparam int PW        = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic [PW-1:0] part_of(input logic [INDEX-1:0] addr);
        logic [INDEX-1:0] q;
        q = addr / INDEX'(PART_SIZE);
        return q[PW-1:0];
    endfunction

    state_t               state_q, state_d;
    logic [INDEX-1:0]     cnt_q, cnt_d;
    logic [NUM_PARTS-1:0] sweep_mask_q, sweep_mask_d;
    logic [NUM_PARTS-1:0] active_q, active_d;
    logic                 illegal_q, illegal_d;
    logic                 init_done_q, init_done_d;

    logic [NUM_PARTS-1:0] new_mask;
    logic [NUM_PARTS-1:0] merged_mask;
    logic                 last_cnt;
    logic                 wr_hits_active;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            sweep_mask_q <= '1;
            active_q     <= '1;
            illegal_q    <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sweep_mask_q <= sweep_mask_d;
            active_q     <= active_d;
            illegal_q    <= illegal_d;
            init_done_q  <= init_done_d;
        end
    end

    assign new_mask       = partitionActive_i & ~active_q;
    assign merged_mask    = (sweep_mask_q | new_mask) & partitionActive_i;
    assign last_cnt       = (cnt_q == INDEX'(DEPTH - 1));
    assign wr_hits_active = active_q[part_of(wrAddr_i)];

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sweep_mask_d = sweep_mask_q;
        active_d     = active_q;
        illegal_d    = illegal_q;
        init_done_d  = 1'b0;

        unique case (state_q)
            SWEEP: begin
                if (reconfig_i) begin
                    // Restart the sweep so newly enabled parts get every entry.
                    active_d     = partitionActive_i;
                    sweep_mask_d = merged_mask;
                    cnt_d        = '0;
                    if (merged_mask == '0) begin
                        state_d     = READY;
                        init_done_d = 1'b1;
                    end
                end else if (last_cnt) begin
                    cnt_d       = '0;
                    state_d     = READY;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + INDEX'(1);
                end
            end
            READY: begin
                if (wrEn_i && !wr_hits_active) begin
                    illegal_d = 1'b1;
                end
                if (reconfig_i) begin
                    active_d = partitionActive_i;
                    if (new_mask != '0) begin
                        state_d      = SWEEP;
                        cnt_d        = '0;
                        sweep_mask_d = new_mask;
                    end
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // Output logic
    always_comb begin
        ramWe_o   = 1'b0;
        ramAddr_o = cnt_q;
        ramData_o = RESET_VAL;

        unique case (state_q)
            SWEEP: begin
                ramWe_o   = sweep_mask_q[part_of(cnt_q)];
                ramAddr_o = cnt_q;
                ramData_o = RESET_VAL;
            end
            READY: begin
                ramWe_o   = wrEn_i & wr_hits_active;
                ramAddr_o = wrAddr_i;
                ramData_o = wrData_i;
            end
            default: ramWe_o = 1'b0;
        endcase

        // No RAM writes leave the block while reset is held.
        if (reset) begin
            ramWe_o = 1'b0;
        end
    end

    assign ready_o      = (state_q == READY);
    assign wrStall_o    = ~ready_o;
    assign initDone_o   = init_done_q;
    assign illegalWr_o  = illegal_q;
    assign activeMask_o = active_q;

endmodule

// File: tb/tb_al_ram_init_sequencer.sv
// Bench for al_ram_init_sequencer: directed plan steps then random traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_al_ram_init_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] partitionActive_i;
    logic       reconfig_i;
    logic       wrEn_i;
    logic [3:0] wrAddr_i;
    logic [7:0] wrData_i;
    logic       wrStall_o;
    logic       ramWe_o;
    logic [3:0] ramAddr_o;
    logic [7:0] ramData_o;
    logic       ready_o;
    logic       initDone_o;
    logic       illegalWr_o;
    logic [3:0] activeMask_o;

    al_ram_init_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .partitionActive_i (partitionActive_i),
        .reconfig_i        (reconfig_i),
        .wrEn_i            (wrEn_i),
        .wrAddr_i          (wrAddr_i),
        .wrData_i          (wrData_i),
        .wrStall_o         (wrStall_o),
        .ramWe_o           (ramWe_o),
        .ramAddr_o         (ramAddr_o),
        .ramData_o         (ramData_o),
        .ready_o           (ready_o),
        .initDone_o        (initDone_o),
        .illegalWr_o       (illegalWr_o),
        .activeMask_o      (activeMask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: sweeping flag, sweep position, set of partitions to clear,
    // applied partition set, sticky illegal flag, done pulse.
    bit       m_known = 0;
    bit       m_busy;
    int       m_pos;
    bit [3:0] m_swp;
    bit [3:0] m_act;
    bit       m_ill;
    bit       m_done;

    function automatic int part(input int a);
        return a / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit       e_we;
        int       e_addr;
        int       e_data;
        if (m_busy) begin
            e_we   = m_swp[part(m_pos)];
            e_addr = m_pos;
            e_data = 0;
        end else begin
            e_we   = wrEn_i && m_act[part(int'(wrAddr_i))];
            e_addr = int'(wrAddr_i);
            e_data = int'(wrData_i);
        end
        if (reset) e_we = 0;
        chk("ready",   32'(ready_o),      32'(!m_busy));
        chk("stall",   32'(wrStall_o),    32'(m_busy));
        chk("we",      32'(ramWe_o),      32'(e_we));
        chk("addr",    32'(ramAddr_o),    32'(e_addr));
        chk("data",    32'(ramData_o),    32'(e_data));
        chk("done",    32'(initDone_o),   32'(m_done));
        chk("illegal", 32'(illegalWr_o),  32'(m_ill));
        chk("mask",    32'(activeMask_o), 32'(m_act));
    endtask

    task automatic model_edge();
        bit [3:0] nm;
        if (reset) begin
            m_known = 1;
            m_busy  = 1;
            m_pos   = 0;
            m_swp   = 4'hF;
            m_act   = 4'hF;
            m_ill   = 0;
            m_done  = 0;
            return;
        end
        if (!m_known) return;
        m_done = 0;
        nm     = partitionActive_i & ~m_act;
        if (m_busy) begin
            if (reconfig_i) begin
                m_act = partitionActive_i;
                m_swp = (m_swp | nm) & partitionActive_i;
                m_pos = 0;
                if (m_swp == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (m_pos == 15) begin
                m_pos  = 0;
                m_busy = 0;
                m_done = 1;
            end else begin
                m_pos++;
            end
        end else begin
            if (wrEn_i && !m_act[part(int'(wrAddr_i))]) m_ill = 1;
            if (reconfig_i) begin
                m_act = partitionActive_i;
                if (nm != 0) begin
                    m_busy = 1;
                    m_pos  = 0;
                    m_swp  = nm;
                end
            end
        end
    endtask

    // Inputs are stable from the negedge; check #1 later, update at posedge.
    task automatic tick();
        #1;
        if (m_known) check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reconfig_i = 0;
        wrEn_i     = 0;
    endtask

    initial begin
        reset             = 1;
        partitionActive_i = 4'hF;
        reconfig_i        = 0;
        wrEn_i            = 0;
        wrAddr_i          = 0;
        wrData_i          = 0;
        @(negedge clk);
        tick();
        tick();

        // Power-on sweep of all 16 entries, then ready with done pulse.
        reset = 0;
        repeat (16) tick();
        tick();
        chk("plan_ready", 32'(ready_o), 32'd1);

        // Producer write pass-through.
        wrEn_i   = 1;
        wrAddr_i = 4'd5;
        wrData_i = 8'hA3;
        tick();
        idle();

        // Disable partitions 2,3: no sweep; write to addr 9 is dropped.
        partitionActive_i = 4'b0011;
        reconfig_i        = 1;
        tick();
        idle();
        wrEn_i   = 1;
        wrAddr_i = 4'd9;
        wrData_i = 8'h5C;
        tick();
        idle();
        tick();
        chk("plan_illegal", 32'(illegalWr_o), 32'd1);

        // Re-enable part 2, then mid-sweep enable part 3 at cnt 6.
        partitionActive_i = 4'b0111;
        reconfig_i        = 1;
        tick();
        idle();
        repeat (6) tick();
        partitionActive_i = 4'b1111;
        reconfig_i        = 1;
        tick();
        idle();
        repeat (16) tick();
        tick();

        // Reset in the middle of a sweep.
        partitionActive_i = 4'b0011;
        reconfig_i        = 1;
        tick();
        partitionActive_i = 4'b1111;
        tick();
        idle();
        repeat (10) tick();
        reset = 1;
        tick();
        reset = 0;
        repeat (18) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            wrEn_i            = 1'($urandom_range(0, 1));
            wrAddr_i          = 4'($urandom);
            wrData_i          = 8'($urandom);
            reconfig_i        = ($urandom_range(0, 19) == 0);
            partitionActive_i = 4'($urandom);
            reset             = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;
        idle();
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
